// File: rtl/nonce_report_pkg.sv
// nonce_report_pkg
// Shared definitions for the golden-nonce reporter: the serializer FSM state
// encoding and the default frame header byte.
// No ports.
package nonce_report_pkg;

    localparam logic [7:0] HDR_BYTE_DEFAULT = 8'h4E;

    // state   | meaning
    // IDLE    | nothing in flight, waiting for a queued nonce
    // HDR     | presenting the frame header byte
    // B3..B0  | presenting nonce bytes, most significant first
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_B3   = 3'd2,
        ST_B2   = 3'd3,
        ST_B1   = 3'd4,
        ST_B0   = 3'd5
    } state_e;

endpackage

// File: rtl/nonce_reporter_sync_fifo.sv
// sync_fifo
// Single-clock FIFO holding golden nonces waiting to be framed.
// Ports:
//   clk      rising-edge clock
//   rst_n    synchronous active-low reset (pointers and count only)
//   flush_i  discard all entries; a coincident push lands in the emptied FIFO
//   push_i   write data_i (accepted if not full, or if a pop frees a slot)
//   data_i   entry to write
//   pop_i    remove head entry (ignored when empty or flushing)
//   head_o   current head entry
//   count_o  number of stored entries
//   drop_o   push rejected this cycle because the FIFO was full
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     drop_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] wr_addr;
    logic [PTR_W:0]   count_q, count_d;
    logic             full, pop_ok, push_ok;

    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    assign pop_ok  = pop_i && (count_q != '0) && !flush_i;
    // A same-cycle pop frees a slot; after a flush there is always room.
    assign push_ok = push_i && (flush_i || !full || pop_ok);
    assign drop_o  = push_i && !push_ok;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        wr_addr  = wr_ptr_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_addr  = '0;
            wr_ptr_d = PTR_W'(push_i);
            count_d  = (PTR_W+1)'(push_i);
        end else begin
            rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
            wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
            count_d  = count_q + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_addr] <= data_i;
        end
    end

endmodule

// File: rtl/nonce_reporter.sv
// nonce_reporter
// Queues golden nonces from the miner core and serializes each one as a
// 5-byte frame (header, then nonce MSB first) towards a UART transmitter
// using a valid/ready handshake.
// Ports:
//   hash_clk          rising-edge clock
//   reset_n           synchronous active-low reset
//   golden_nonce      nonce, valid with new_golden_nonce
//   new_golden_nonce  single-cycle strobe
//   flush             new-work pulse, discards queued nonces and clears overflow
//   tx_data/tx_valid  byte towards the transmitter
//   tx_ready          transmitter accepts the byte this cycle
//   fifo_count        queued nonces, not counting the frame in flight
//   overflow          sticky, a nonce was dropped on a full FIFO
module nonce_reporter
    import nonce_report_pkg::*;
#(
    parameter int         DEPTH    = 4,
    parameter logic [7:0] HDR_BYTE = HDR_BYTE_DEFAULT
) (
    input  logic                   hash_clk,
    input  logic                   reset_n,
    input  logic [31:0]            golden_nonce,
    input  logic                   new_golden_nonce,
    input  logic                   flush,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow
);

    state_e      state_q;
    logic [31:0] frame_q;
    logic [7:0]  tx_data_q;
    logic        tx_valid_q;
    logic        overflow_q;

    logic [31:0] fifo_head;
    logic        fifo_drop;
    logic        load;

    // Start a new frame from IDLE, or chain directly after the last byte is
    // accepted. A flush suppresses the pop so discarded nonces are never sent.
    assign load = (fifo_count != '0) && !flush &&
                  ((state_q == ST_IDLE) || ((state_q == ST_B0) && tx_ready));

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (hash_clk),
        .rst_n   (reset_n),
        .flush_i (flush),
        .push_i  (new_golden_nonce),
        .data_i  (golden_nonce),
        .pop_i   (load),
        .head_o  (fifo_head),
        .count_o (fifo_count),
        .drop_o  (fifo_drop)
    );

    always_ff @(posedge hash_clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            frame_q    <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (flush) begin
                overflow_q <= 1'b0;
            end else if (fifo_drop) begin
                overflow_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (load) begin
                        frame_q    <= fifo_head;
                        state_q    <= ST_HDR;
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= HDR_BYTE;
                    end
                end
                ST_HDR: begin
                    if (tx_ready) begin
                        state_q   <= ST_B3;
                        tx_data_q <= frame_q[31:24];
                    end
                end
                ST_B3: begin
                    if (tx_ready) begin
                        state_q   <= ST_B2;
                        tx_data_q <= frame_q[23:16];
                    end
                end
                ST_B2: begin
                    if (tx_ready) begin
                        state_q   <= ST_B1;
                        tx_data_q <= frame_q[15:8];
                    end
                end
                ST_B1: begin
                    if (tx_ready) begin
                        state_q   <= ST_B0;
                        tx_data_q <= frame_q[7:0];
                    end
                end
                ST_B0: begin
                    if (tx_ready) begin
                        if (load) begin
                            frame_q    <= fifo_head;
                            state_q    <= ST_HDR;
                            tx_valid_q <= 1'b1;
                            tx_data_q  <= HDR_BYTE;
                        end else begin
                            state_q    <= ST_IDLE;
                            tx_valid_q <= 1'b0;
                            tx_data_q  <= 8'h00;
                        end
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    tx_valid_q <= 1'b0;
                    tx_data_q  <= 8'h00;
                end
            endcase
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_nonce_reporter.sv
module tb_nonce_reporter;

    logic        hash_clk;
    logic        reset_n;
    logic [31:0] golden_nonce;
    logic        new_golden_nonce;
    logic        flush;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [2:0]  fifo_count;
    logic        overflow;

    int n_cmp;
    int n_bad;
    logic [7:0] exp_q[$];

    nonce_reporter #(.DEPTH(4), .HDR_BYTE(8'h4E)) dut (
        .hash_clk         (hash_clk),
        .reset_n          (reset_n),
        .golden_nonce     (golden_nonce),
        .new_golden_nonce (new_golden_nonce),
        .flush            (flush),
        .tx_data          (tx_data),
        .tx_valid         (tx_valid),
        .tx_ready         (tx_ready),
        .fifo_count       (fifo_count),
        .overflow         (overflow)
    );

    initial hash_clk = 1'b0;
    always #5 hash_clk = ~hash_clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge hash_clk);
    endtask

    function automatic void add_frame(input logic [31:0] n);
        exp_q.push_back(8'h4E);
        exp_q.push_back(n[31:24]);
        exp_q.push_back(n[23:16]);
        exp_q.push_back(n[15:8]);
        exp_q.push_back(n[7:0]);
    endfunction

    task automatic test_reset();
        reset_n = 1'b0; new_golden_nonce = 1'b1; golden_nonce = 32'h11223344;
        flush = 1'b0; tx_ready = 1'b1;
        repeat (2) step();
        n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %0b want 0", tx_valid); end
        n_cmp++; if (tx_data !== 8'h00) begin n_bad++; $display("FAIL reset_data got %h want 00", tx_data); end
        n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", fifo_count); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got %0b want 0", overflow); end
        reset_n = 1'b1; new_golden_nonce = 1'b0;
        step();
        n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_release_valid got %0b want 0", tx_valid); end
    endtask

    task automatic test_single();
        golden_nonce = 32'hDEADBEEF; new_golden_nonce = 1'b1; tx_ready = 1'b1;
        step();
        new_golden_nonce = 1'b0;
        n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL single_n1_valid got %0b want 0", tx_valid); end
        n_cmp++; if (fifo_count !== 3'd1) begin n_bad++; $display("FAIL single_n1_count got %0d want 1", fifo_count); end
        step();
        exp_q.delete(); add_frame(32'hDEADBEEF);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++; if (tx_valid !== 1'b1 || tx_data !== exp_q[i]) begin
                n_bad++; $display("FAIL single_byte%0d got v=%0b d=%h want v=1 d=%h", i, tx_valid, tx_data, exp_q[i]);
            end
            step();
        end
        n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL single_end_valid got %0b want 0", tx_valid); end
        n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL single_end_count got %0d want 0", fifo_count); end
    endtask

    task automatic test_stall();
        logic [7:0] pat;
        int idx;
        pat = 8'b1110_1001;  // bit i = tx_ready in cycle i: 1,0,0,1,0,1,1,1
        tx_ready = 1'b0; golden_nonce = 32'h01020304; new_golden_nonce = 1'b1;
        step();
        new_golden_nonce = 1'b0;
        step();
        exp_q.delete(); add_frame(32'h01020304);
        idx = 0;
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (tx_valid !== 1'b1 || tx_data !== exp_q[idx]) begin
                n_bad++; $display("FAIL stall_cyc%0d got v=%0b d=%h want v=1 d=%h", i, tx_valid, tx_data, exp_q[idx]);
            end
            tx_ready = pat[i];
            step();
            if (pat[i]) idx++;
        end
        n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL stall_end_valid got %0b want 0", tx_valid); end
        tx_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        tx_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            golden_nonce = 32'h11111111 * (k + 1); new_golden_nonce = 1'b1;
            step();
        end
        new_golden_nonce = 1'b0;
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL b2b_ovf got %0b want 1", overflow); end
        n_cmp++; if (fifo_count !== 3'd4) begin n_bad++; $display("FAIL b2b_count got %0d want 4", fifo_count); end
        n_cmp++; if (tx_valid !== 1'b1 || tx_data !== 8'h4E) begin
            n_bad++; $display("FAIL b2b_hdr got v=%0b d=%h want v=1 d=4e", tx_valid, tx_data);
        end
        exp_q.delete();
        for (int k = 0; k < 5; k++) add_frame(32'h11111111 * (k + 1));
        tx_ready = 1'b1;
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++; if (tx_valid !== 1'b1 || tx_data !== exp_q[i]) begin
                n_bad++; $display("FAIL b2b_byte%0d got v=%0b d=%h want v=1 d=%h", i, tx_valid, tx_data, exp_q[i]);
            end
            step();
        end
        n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_end_valid got %0b want 0", tx_valid); end
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL b2b_sticky got %0b want 1", overflow); end
    endtask

    task automatic test_full_pop_push();
        flush = 1'b1; tx_ready = 1'b0;
        step();
        flush = 1'b0;
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL fpp_flush_ovf got %0b want 0", overflow); end
        for (int k = 0; k < 5; k++) begin
            golden_nonce = 32'hA0000001 + k; new_golden_nonce = 1'b1;
            step();
        end
        new_golden_nonce = 1'b0;
        n_cmp++; if (fifo_count !== 3'd4) begin n_bad++; $display("FAIL fpp_full_count got %0d want 4", fifo_count); end
        tx_ready = 1'b1;
        repeat (4) step();
        n_cmp++; if (tx_data !== 8'h01) begin n_bad++; $display("FAIL fpp_b0 got %h want 01", tx_data); end
        golden_nonce = 32'hCAFEF00D; new_golden_nonce = 1'b1;
        step();
        new_golden_nonce = 1'b0;
        n_cmp++; if (fifo_count !== 3'd4) begin n_bad++; $display("FAIL fpp_count got %0d want 4", fifo_count); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL fpp_ovf got %0b want 0", overflow); end
        exp_q.delete();
        for (int k = 1; k < 5; k++) add_frame(32'hA0000001 + k);
        add_frame(32'hCAFEF00D);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++; if (tx_valid !== 1'b1 || tx_data !== exp_q[i]) begin
                n_bad++; $display("FAIL fpp_byte%0d got v=%0b d=%h want v=1 d=%h", i, tx_valid, tx_data, exp_q[i]);
            end
            step();
        end
        n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL fpp_end_valid got %0b want 0", tx_valid); end
    endtask

    task automatic test_flush_mid_frame();
        tx_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            golden_nonce = (k == 0) ? 32'hF1A2B3C4 : 32'h0F000000 + k; new_golden_nonce = 1'b1;
            step();
        end
        new_golden_nonce = 1'b0;
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL flush_pre_ovf got %0b want 1", overflow); end
        tx_ready = 1'b1;
        repeat (2) step();
        n_cmp++; if (tx_data !== 8'hA2) begin n_bad++; $display("FAIL flush_b2 got %h want a2", tx_data); end
        flush = 1'b1; golden_nonce = 32'h00000055; new_golden_nonce = 1'b1;
        step();
        flush = 1'b0; new_golden_nonce = 1'b0;
        n_cmp++; if (fifo_count !== 3'd1) begin n_bad++; $display("FAIL flush_count got %0d want 1", fifo_count); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL flush_ovf got %0b want 0", overflow); end
        exp_q.delete();
        exp_q.push_back(8'hB3); exp_q.push_back(8'hC4);
        add_frame(32'h00000055);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++; if (tx_valid !== 1'b1 || tx_data !== exp_q[i]) begin
                n_bad++; $display("FAIL flush_byte%0d got v=%0b d=%h want v=1 d=%h", i, tx_valid, tx_data, exp_q[i]);
            end
            step();
        end
        n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL flush_end_valid got %0b want 0", tx_valid); end
        n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL flush_end_count got %0d want 0", fifo_count); end
    endtask

    task automatic test_reset_mid_frame();
        tx_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            golden_nonce = 32'h12345678 + (k << 8); new_golden_nonce = 1'b1;
            step();
        end
        new_golden_nonce = 1'b0;
        tx_ready = 1'b1;
        repeat (2) step();
        n_cmp++; if (tx_data !== 8'h34) begin n_bad++; $display("FAIL rst_b2 got %h want 34", tx_data); end
        reset_n = 1'b0; new_golden_nonce = 1'b1; golden_nonce = 32'h99999999;
        step();
        reset_n = 1'b1; new_golden_nonce = 1'b0;
        n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_valid got %0b want 0", tx_valid); end
        n_cmp++; if (tx_data !== 8'h00) begin n_bad++; $display("FAIL rst_mid_data got %h want 00", tx_data); end
        n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL rst_mid_count got %0d want 0", fifo_count); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL rst_mid_ovf got %0b want 0", overflow); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL rst_after%0d_valid got %0b want 0", i, tx_valid); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_bad = 0;
        reset_n = 1'b0; golden_nonce = '0; new_golden_nonce = 1'b0;
        flush = 1'b0; tx_ready = 1'b0;
        step();
        test_reset();
        test_single();
        test_stall();
        test_back_to_back();
        test_full_pop_push();
        test_flush_mid_frame();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
